// File: rtl/vector_lane_streamer.sv
// vector_lane_streamer
//   Captures a LANES-wide vector on START and streams it out one lane per
//   accepted transfer over a VALID/READY handshake. A single-cycle DONE
//   pulse follows the last transfer.
//
//   Optional feature macro: VSTREAM_SKIP_ZERO_EN -- when defined, lanes whose
//   captured value is zero are skipped. IDX still reports the true lane
//   number. An all-zero vector goes straight to the DONE cycle.
//
// Ports
//   CLK    in   clock, all state changes on posedge
//   RST    in   synchronous reset, active-low
//   VEC    in   LANES*W vector, lane i = VEC[i*W +: W]
//   START  in   capture VEC and begin streaming (sampled in IDLE only)
//   READY  in   consumer accepts ELEM when VALID=1
//   ELEM   out  current lane element
//   IDX    out  lane number of ELEM
//   VALID  out  ELEM/IDX valid
//   BUSY   out  high whenever not idle
//   DONE   out  one-cycle pulse after the final transfer
module vector_lane_streamer #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [LANES*W-1:0]         VEC,
  input  logic                       START,
  input  logic                       READY,
  output logic [W-1:0]               ELEM,
  output logic [$clog2(LANES)-1:0]   IDX,
  output logic                       VALID,
  output logic                       BUSY,
  output logic                       DONE
);

  localparam int IW = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FIN
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [W-1:0]  shadow_reg [LANES];
  logic [W-1:0]  vec_lane   [LANES];
  logic          capture;

  // Lane selection: where a new stream starts, and where it goes after the
  // current lane is accepted. *_found=0 means there is no such lane.
  logic          first_found;
  logic [IW-1:0] first_idx;
  logic          next_found;
  logic [IW-1:0] next_idx;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_unpack
      assign vec_lane[gi] = VEC[gi*W +: W];
    end
  endgenerate

`ifdef VSTREAM_SKIP_ZERO_EN
  // Scan from the top lane down so the lowest qualifying lane wins.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vec_lane[i] != '0) begin
        first_found = 1'b1;
        first_idx   = IW'(i);
      end
      if ((i > int'(ptr_reg)) && (shadow_reg[i] != '0)) begin
        next_found = 1'b1;
        next_idx   = IW'(i);
      end
    end
  end
`else
  // Every lane is emitted in order; the stream ends at the top lane.
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign next_found  = (ptr_reg != IW'(LANES - 1));
  assign next_idx    = ptr_reg + 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (START) begin
          capture    = 1'b1;
          ptr_next   = first_idx;
          state_next = first_found ? S_STREAM : S_FIN;
        end
      end
      S_STREAM: begin
        if (READY) begin
          // At the last lane the pointer holds; it never wraps.
          if (next_found) begin
            ptr_next = next_idx;
          end else begin
            state_next = S_FIN;
          end
        end
      end
      S_FIN: begin
        // START is not looked at here, so a held START starts the next
        // stream only from the following IDLE cycle.
        state_next = S_IDLE;
        ptr_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      for (int i = 0; i < LANES; i++) begin
        shadow_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (capture) begin
        for (int i = 0; i < LANES; i++) begin
          shadow_reg[i] <= vec_lane[i];
        end
      end
    end
  end

  assign ELEM  = shadow_reg[ptr_reg];
  assign IDX   = ptr_reg;
  assign VALID = (state_reg == S_STREAM);
  assign BUSY  = (state_reg != S_IDLE);
  assign DONE  = (state_reg == S_FIN);

endmodule
